memory_access: RTL and testbench
================================

# memory_access

Memory stage of the 5-stage MIPS pipeline, between execute and writeback. Each cycle it consumes execute's registered outputs, performs the LW/SW access against an internal word-addressed data memory, and registers the writeback payload (type, target, data) for writeback and for the data-path forwarding muxes. It also keeps load/store statistics and tracks program completion through a small run/halt state machine.

## Interface
- `ADDR_W`, 8: data-memory address width in words; depth = 2^ADDR_W.
- `CNT_W`, 16: width of the load/store counters.

- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `done_in`  in  1  program-complete flag from execute.
- `instr_type_EX`  in  4  instruction code: 1–12 ALU, 13 LW, 14 SW, others nop.
- `wb_tgt_EX`  in  5  destination register.
- `result`  in  32  signed ALU result; for LW the byte-free word address; for SW the store data.
- `sw_addr`  in  16  SW word address.
- `instr_type_MEM`  out  4  registered instruction code.
- `wb_tgt_MEM`  out  5  registered destination register.
- `wb_data_MEM`  out  32  registered writeback/forwarding data.
- `done_out`  out  1  registered completion flag.
- `load_count`  out  CNT_W  LW instructions retired in RUN.
- `store_count`  out  CNT_W  SW instructions retired in RUN.
- `mem_busy`  out  1  memory clear in progress (see Configuration).

## Operation
- Address truncation: LW uses `result[ADDR_W-1:0]`; SW uses `sw_addr[ADDR_W-1:0]`. Upper bits ignored, so addresses wrap modulo 2^ADDR_W. No alignment check; addresses are word indices.
- Type 13 (LW): `wb_data_MEM <= mem[addr]`, a synchronous read.
- Type 14 (SW): `mem[addr] <= result`. `wb_data_MEM <= result`. The writeback stage ignores the target for SW.
- Types 1–12: `wb_data_MEM <= result`. No memory access.
- Other types (0, 15): `wb_data_MEM <= 0`. No memory access.
- `instr_type_MEM` and `wb_tgt_MEM` always follow their inputs with one cycle of delay.
- FSM states:
  - RUN (entered on reset): counters increment by 1 per LW/SW. Moves to HALT in the cycle `done_in`=1 is sampled. The instruction sampled in that cycle is still counted.
  - HALT: counters frozen. Memory access and data path continue unchanged. Exits only on reset.
- Counters saturate at all-ones and do not wrap.
- `done_out <= done_in`, independent of FSM state.

## Timing
- Latency: 1 cycle, input sampled at edge N → outputs valid after edge N. No stalls, no backpressure.
- SW at edge N followed by LW to the same address sampled at edge N+1 returns the new data (write completes at N). No bypass logic is needed.
- Reset (any cycle, including mid-program): all outputs 0 on the next edge: `instr_type_MEM`, `wb_tgt_MEM`, `wb_data_MEM`, `done_out`, `load_count`, `store_count`, `mem_busy`. FSM returns to RUN. Memory contents are not reset, except as described under Configuration.
- A SW sampled in the same cycle as `reset`=1 does not write.

## Configuration
- `MEM_CLEAR_EN` defined:
  - A clear sequencer starts in the cycle after `reset` deasserts. It writes 0 to addresses 0…2^ADDR_W−1, one per cycle, with `mem_busy`=1 throughout.
  - While busy, SW writes are dropped (not counted), LW returns 0 (counted), and the ALU path is unaffected.
  - `mem_busy` falls after the last word is written, 2^ADDR_W cycles after reset release.
  - Reset during the clear restarts it from address 0.
- Without `MEM_CLEAR_EN`: no sequencer, `mem_busy` is tied 0, and memory starts uninitialised (X in simulation).

## Test plan
- Reset, then SW `result`=0xDEADBEEF with `sw_addr`=0x0005, then LW `result`=5 → `wb_data_MEM`=0xDEADBEEF one cycle after the LW; `store_count`=1, `load_count`=1.
- Address wrap at ADDR_W=8: SW `sw_addr`=0x0103 with data 0x12, then LW `result`=3 → 0x12.
- ADD type 1 with `result`=0xFFFFFFF0, `wb_tgt_EX`=7 → next cycle type 1, tgt 7, data 0xFFFFFFF0; counters unchanged; nop type 0 → data 0.
- `done_in`=1 together with a LW, then 3 more SW → `load_count`=1, `store_count`=0, `done_out`=1 one cycle later, and the stores still write memory.
- Reset asserted mid-stream with a SW present → no write occurs; all outputs 0 next cycle.
- With `MEM_CLEAR_EN`, ADDR_W=4: `mem_busy` is high for exactly 16 cycles after reset release; an SW during the clear is dropped; a LW of any address afterwards returns 0.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MIPS memory stage: LW/SW data memory, writeback register, load/store stats
// Optional MEM_CLEAR_EN: zero the data memory after every reset release, one word per cycle.
module memory_access #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done_in,
    input  logic [3:0]        instr_type_EX,
    input  logic [4:0]        wb_tgt_EX,
    input  logic [31:0]       result,
    input  logic [15:0]       sw_addr,
    output logic [3:0]        instr_type_MEM,
    output logic [4:0]        wb_tgt_MEM,
    output logic [31:0]       wb_data_MEM,
    output logic              done_out,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count,
    output logic              mem_busy
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [3:0] T_LW    = 4'd13;
    localparam logic [3:0] T_SW    = 4'd14;
    localparam int         DEPTH   = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic [3:0]        instr_type_q, instr_type_d;
    logic [4:0]        wb_tgt_q, wb_tgt_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  load_count_q, load_count_d;
    logic [CNT_W-1:0]  store_count_q, store_count_d;
    logic [0:0]        state_q, state_d;

    logic              is_lw, is_sw, is_alu;
    logic              clearing, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              unused_sw_addr_hi;

    assign unused_sw_addr_hi = ^sw_addr[15:ADDR_W];
    assign is_lw  = (instr_type_EX == T_LW);
    assign is_sw  = (instr_type_EX == T_SW);
    assign is_alu = (instr_type_EX >= 4'd1) && (instr_type_EX <= 4'd12);

`ifdef MEM_CLEAR_EN
    logic              clr_pend_q, clr_pend_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Reset arms the sequencer; busy rises on the first edge with reset low.
    always_comb begin
        clr_pend_d = 1'b0;
        busy_d     = busy_q;
        clr_addr_d = clr_addr_q;
        if (reset) begin
            clr_pend_d = 1'b1;
            busy_d     = 1'b0;
            clr_addr_d = '0;
        end else if (clr_pend_q) begin
            busy_d     = 1'b1;
            clr_addr_d = '0;
        end else if (busy_q) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        clr_pend_q <= clr_pend_d;
        busy_q     <= busy_d;
        clr_addr_q <= clr_addr_d;
    end

    assign clearing = clr_pend_q | busy_q;
    assign clr_we   = busy_q & ~reset;
    assign clr_addr = clr_addr_q;
    assign mem_busy = busy_q;
`else
    assign clearing = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign mem_busy = 1'b0;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sw_addr[ADDR_W-1:0];
        mem_wdata = result;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (is_sw && !clearing && !reset) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        instr_type_d  = instr_type_EX;
        wb_tgt_d      = wb_tgt_EX;
        done_d        = done_in;
        wb_data_d     = '0;
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        state_d       = state_q;

        if (is_lw)
            wb_data_d = clearing ? 32'd0 : mem[result[ADDR_W-1:0]];
        else if (is_sw || is_alu)
            wb_data_d = result;

        // The instruction sampled together with done_in is still counted.
        if (state_q == ST_RUN) begin
            if (is_lw && load_count_q != '1)
                load_count_d = load_count_q + 1'b1;
            if (is_sw && !clearing && store_count_q != '1)
                store_count_d = store_count_q + 1'b1;
            if (done_in)
                state_d = ST_HALT;
        end

        if (reset) begin
            instr_type_d  = '0;
            wb_tgt_d      = '0;
            wb_data_d     = '0;
            done_d        = 1'b0;
            load_count_d  = '0;
            store_count_d = '0;
            state_d       = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        instr_type_q  <= instr_type_d;
        wb_tgt_q      <= wb_tgt_d;
        wb_data_q     <= wb_data_d;
        done_q        <= done_d;
        load_count_q  <= load_count_d;
        store_count_q <= store_count_d;
        state_q       <= state_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign instr_type_MEM = instr_type_q;
    assign wb_tgt_MEM     = wb_tgt_q;
    assign wb_data_MEM    = wb_data_q;
    assign done_out       = done_q;
    assign load_count     = load_count_q;
    assign store_count    = store_count_q;
endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed table-driven bench for memory_access
// Default build runs the data-path table; MEM_CLEAR_EN build runs the clear sequence.
module tb_memory_access;
`ifdef MEM_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 8;
`endif

    logic        clk = 1'b0;
    logic        reset, done_in;
    logic [3:0]  instr_type_EX;
    logic [4:0]  wb_tgt_EX;
    logic [31:0] result;
    logic [15:0] sw_addr;
    logic [3:0]  instr_type_MEM;
    logic [4:0]  wb_tgt_MEM;
    logic [31:0] wb_data_MEM;
    logic        done_out;
    logic [15:0] load_count, store_count;
    logic        mem_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_access #(.ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .done_in(done_in),
        .instr_type_EX(instr_type_EX), .wb_tgt_EX(wb_tgt_EX),
        .result(result), .sw_addr(sw_addr),
        .instr_type_MEM(instr_type_MEM), .wb_tgt_MEM(wb_tgt_MEM),
        .wb_data_MEM(wb_data_MEM), .done_out(done_out),
        .load_count(load_count), .store_count(store_count),
        .mem_busy(mem_busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  itype;
        logic [4:0]  tgt;
        logic [31:0] res;
        logic [15:0] swa;
        logic        done;
        logic [3:0]  e_type;
        logic [4:0]  e_tgt;
        logic [31:0] e_data;
        logic [15:0] e_lc;
        logic [15:0] e_sc;
        logic        e_done;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] itype, input logic [4:0] tgt,
                                input logic [31:0] res, input logic [15:0] swa, input logic done,
                                input logic [3:0] e_type, input logic [4:0] e_tgt,
                                input logic [31:0] e_data, input logic [15:0] e_lc,
                                input logic [15:0] e_sc, input logic e_done);
        vec_t v;
        v.rst = rst; v.itype = itype; v.tgt = tgt; v.res = res; v.swa = swa; v.done = done;
        v.e_type = e_type; v.e_tgt = e_tgt; v.e_data = e_data;
        v.e_lc = e_lc; v.e_sc = e_sc; v.e_done = e_done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] t, input logic [4:0] tgt,
                         input logic [31:0] res, input logic [15:0] swa, input logic done);
        reset = rst; instr_type_EX = t; wb_tgt_EX = tgt;
        result = res; sw_addr = swa; done_in = done;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] t, input logic [4:0] tgt,
                             input logic [31:0] d, input logic [15:0] lc, input logic [15:0] sc,
                             input logic dn);
        check({tag, ".type"},  {28'd0, instr_type_MEM}, {28'd0, t});
        check({tag, ".tgt"},   {27'd0, wb_tgt_MEM},     {27'd0, tgt});
        check({tag, ".data"},  wb_data_MEM,             d);
        check({tag, ".lc"},    {16'd0, load_count},     {16'd0, lc});
        check({tag, ".sc"},    {16'd0, store_count},    {16'd0, sc});
        check({tag, ".done"},  {31'd0, done_out},       {31'd0, dn});
    endtask

`ifndef MEM_CLEAR_EN
    vec_t vecs[22];
`endif

    initial begin
        drive(1'b1, 4'd0, 5'd0, 32'd0, 16'd0, 1'b0);
        step();
        step();
        check_all("reset", 4'd0, 5'd0, 32'd0, 16'd0, 16'd0, 1'b0);
        check("reset.busy", {31'd0, mem_busy}, 32'd0);

`ifndef MEM_CLEAR_EN
        vecs[0]  = mk(0, 14, 0,  32'hDEADBEEF, 16'h0005, 0, 14, 0,  32'hDEADBEEF, 0, 1, 0);
        vecs[1]  = mk(0, 13, 3,  32'd5,        16'h0000, 0, 13, 3,  32'hDEADBEEF, 1, 1, 0);
        vecs[2]  = mk(0, 14, 0,  32'h12,       16'h0103, 0, 14, 0,  32'h12,       1, 2, 0);
        vecs[3]  = mk(0, 13, 4,  32'd3,        16'h0000, 0, 13, 4,  32'h12,       2, 2, 0);
        vecs[4]  = mk(0, 1,  7,  32'hFFFFFFF0, 16'h0000, 0, 1,  7,  32'hFFFFFFF0, 2, 2, 0);
        vecs[5]  = mk(0, 0,  9,  32'h1234,     16'h0000, 0, 0,  9,  32'd0,        2, 2, 0);
        vecs[6]  = mk(0, 15, 1,  32'd5,        16'h0000, 0, 15, 1,  32'd0,        2, 2, 0);
        vecs[7]  = mk(0, 12, 31, 32'h7FFFFFFF, 16'h0000, 0, 12, 31, 32'h7FFFFFFF, 2, 2, 0);
        vecs[8]  = mk(0, 13, 2,  32'h105,      16'h0000, 0, 13, 2,  32'hDEADBEEF, 3, 2, 0);
        vecs[9]  = mk(0, 14, 0,  32'hCAFEF00D, 16'hFF05, 0, 14, 0,  32'hCAFEF00D, 3, 3, 0);
        vecs[10] = mk(0, 13, 6,  32'd5,        16'h0000, 0, 13, 6,  32'hCAFEF00D, 4, 3, 0);
        // Reset with a SW and done_in present: no write, everything clears.
        vecs[11] = mk(1, 14, 8,  32'h55555555, 16'h0005, 1, 0,  0,  32'd0,        0, 0, 0);
        vecs[12] = mk(0, 13, 6,  32'd5,        16'h0000, 0, 13, 6,  32'hCAFEF00D, 1, 0, 0);
        vecs[13] = mk(0, 13, 5,  32'd3,        16'h0000, 1, 13, 5,  32'h12,       2, 0, 1);
        vecs[14] = mk(0, 14, 0,  32'hA,        16'd10,   0, 14, 0,  32'hA,        2, 0, 0);
        vecs[15] = mk(0, 14, 0,  32'hB,        16'd11,   0, 14, 0,  32'hB,        2, 0, 0);
        vecs[16] = mk(0, 14, 0,  32'hC,        16'd12,   0, 14, 0,  32'hC,        2, 0, 0);
        vecs[17] = mk(0, 13, 1,  32'd10,       16'h0000, 0, 13, 1,  32'hA,        2, 0, 0);
        vecs[18] = mk(0, 13, 1,  32'd12,       16'h0000, 0, 13, 1,  32'hC,        2, 0, 0);
        vecs[19] = mk(0, 13, 1,  32'd11,       16'h0000, 0, 13, 1,  32'hB,        2, 0, 0);
        vecs[20] = mk(1, 0,  0,  32'd0,        16'h0000, 0, 0,  0,  32'd0,        0, 0, 0);
        vecs[21] = mk(0, 13, 6,  32'd5,        16'h0000, 0, 13, 6,  32'hCAFEF00D, 1, 0, 0);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].itype, vecs[i].tgt, vecs[i].res, vecs[i].swa, vecs[i].done);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_type, vecs[i].e_tgt, vecs[i].e_data,
                      vecs[i].e_lc, vecs[i].e_sc, vecs[i].e_done);
            check($sformatf("vec%0d.busy", i), {31'd0, mem_busy}, 32'd0);
        end
`else
        begin
            int n;
            // Let the first clear finish, then plant data that the next clear must wipe.
            drive(1'b0, 4'd0, 5'd0, 32'd0, 16'd0, 1'b0);
            n = 0;
            step();
            while (mem_busy && n < 40) begin n++; step(); end
            check("clear1.cycles", n, 16);
            drive(1'b0, 4'd14, 5'd0, 32'h99, 16'd2, 1'b0);  step();
            drive(1'b0, 4'd14, 5'd0, 32'h42, 16'd7, 1'b0);  step();
            drive(1'b0, 4'd13, 5'd0, 32'd7, 16'd0, 1'b0);   step();
            check("preclear.lw7", wb_data_MEM, 32'h42);

            drive(1'b1, 4'd0, 5'd0, 32'd0, 16'd0, 1'b0);
            step();
            check("clr.reset.busy", {31'd0, mem_busy}, 32'd0);
            drive(1'b0, 4'd0, 5'd0, 32'd0, 16'd0, 1'b0);
            step();
            n = 0;
            while (mem_busy && n < 40) begin
                n++;
                if (n == 2)      drive(1'b0, 4'd14, 5'd0, 32'h55, 16'd3, 1'b0);
                else if (n == 4) drive(1'b0, 4'd13, 5'd1, 32'd7, 16'd0, 1'b0);
                else if (n == 6) drive(1'b0, 4'd1,  5'd2, 32'h77, 16'd0, 1'b0);
                else             drive(1'b0, 4'd0,  5'd0, 32'd0, 16'd0, 1'b0);
                step();
                if (n == 4) check("busy.lw", wb_data_MEM, 32'd0);
                if (n == 6) check("busy.alu", wb_data_MEM, 32'h77);
            end
            check("clear2.cycles", n, 16);
            check("clear.sc", {16'd0, store_count}, 32'd0);
            check("clear.lc", {16'd0, load_count}, 32'd1);
            drive(1'b0, 4'd13, 5'd0, 32'd2, 16'd0, 1'b0);  step();
            check("after.lw2", wb_data_MEM, 32'd0);
            drive(1'b0, 4'd13, 5'd0, 32'd7, 16'd0, 1'b0);  step();
            check("after.lw7", wb_data_MEM, 32'd0);
            drive(1'b0, 4'd13, 5'd0, 32'd3, 16'd0, 1'b0);  step();
            check("after.lw3", wb_data_MEM, 32'd0);
            drive(1'b0, 4'd14, 5'd0, 32'h55, 16'h0013, 1'b0);  step();
            drive(1'b0, 4'd13, 5'd0, 32'd3, 16'd0, 1'b0);  step();
            check("after.sw_lw3", wb_data_MEM, 32'h55);
            check("after.sc", {16'd0, store_count}, 32'd1);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
